// File: rtl/ck_rst_seq_if.sv
// ck_rst_seq_if: sequencer control/status bundle; master drives requests, slave is the sequencer.
interface ck_rst_seq_if #(
    parameter int NUM_RST   = 3,
    parameter int DIV_WIDTH = 8
);
    logic                 sw_rst_req;
    logic [DIV_WIDTH-1:0] div_val;
    logic [NUM_RST-1:0]   rst_n_out;
    logic                 rst_done;
    logic                 ck_en;
    modport master (output sw_rst_req, div_val, input rst_n_out, rst_done, ck_en);
    modport slave  (input sw_rst_req, div_val, output rst_n_out, rst_done, ck_en);
endinterface

// File: rtl/ck_rst_seq.sv
// ck_rst_seq: synchronises board reset, releases staggered reset domains, then runs a clock-enable divider.
module ck_rst_seq #(
    parameter int NUM_RST     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 2,
    parameter int DIV_WIDTH   = 8
) (
    input  logic          clk,
    input  logic          reset,
    ck_rst_seq_if.slave   bus
);
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int SW = $clog2(STAGGER + 1) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER - 1);
    localparam bit FAST = (STAGGER == 0) || (NUM_RST == 1);

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    state_t               state, state_d;
    logic [SYNC_STAGES-1:0] sync;
    logic [HW-1:0]        hold_cnt, hold_d;
    logic [SW-1:0]        stag_cnt, stag_d;
    logic [NUM_RST-1:0]   rst_q, rst_d, rst_sh;
    logic [NUM_RST:0]     rst_ext;
    logic [DIV_WIDTH-1:0] div_cnt, div_cnt_d, div_lat, div_lat_d;
    logic                 ck_q, ck_d;
    logic                 rst_sync;

    assign rst_sync = sync[SYNC_STAGES-1];
    assign rst_ext  = {rst_q, 1'b1};
    assign rst_sh   = rst_ext[NUM_RST-1:0];

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sync     <= '0;
            state    <= HOLD;
            hold_cnt <= '0;
            stag_cnt <= '0;
            rst_q    <= '0;
            div_cnt  <= '0;
            div_lat  <= '0;
            ck_q     <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], 1'b1};
            state    <= state_d;
            hold_cnt <= hold_d;
            stag_cnt <= stag_d;
            rst_q    <= rst_d;
            div_cnt  <= div_cnt_d;
            div_lat  <= div_lat_d;
            ck_q     <= ck_d;
        end

    // Software request overrides every state; the divider latches its period on RUN entry and each wrap.
    always_comb begin
        state_d   = state;
        hold_d    = hold_cnt;
        stag_d    = stag_cnt;
        rst_d     = rst_q;
        div_cnt_d = div_cnt;
        div_lat_d = div_lat;
        ck_d      = 1'b0;
        if (bus.sw_rst_req) begin
            state_d   = HOLD;
            hold_d    = '0;
            stag_d    = '0;
            rst_d     = '0;
            div_cnt_d = '0;
        end else begin
            case (state)
                HOLD:
                    if (rst_sync) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_d    = '0;
                            rst_d     = FAST ? '1 : NUM_RST'(1);
                            state_d   = FAST ? RUN : RELEASE;
                            div_cnt_d = '0;
                            div_lat_d = bus.div_val;
                        end else
                            hold_d = hold_cnt + HW'(1);
                    end
                RELEASE:
                    if (stag_cnt == STAG_LAST) begin
                        stag_d = '0;
                        rst_d  = rst_sh;
                        if (&rst_sh) begin
                            state_d   = RUN;
                            div_cnt_d = '0;
                            div_lat_d = bus.div_val;
                        end
                    end else
                        stag_d = stag_cnt + SW'(1);
                RUN:
                    if (div_cnt == div_lat) begin
                        div_cnt_d = '0;
                        div_lat_d = bus.div_val;
                        ck_d      = 1'b1;
                    end else
                        div_cnt_d = div_cnt + DIV_WIDTH'(1);
                default: state_d = HOLD;
            endcase
        end
    end

    always_comb begin
        bus.rst_n_out = rst_q;
        bus.rst_done  = state == RUN;
        bus.ck_en     = ck_q;
    end
endmodule

// File: tb/tb_ck_rst_seq.sv
// tb_ck_rst_seq: two sequencer configurations checked each cycle against an edge-count model.
module tb_ck_rst_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw = 1'b0;
    logic [7:0] dv = 8'd3;
    int         vectors = 0;
    int         miscompares = 0;

    ck_rst_seq_if #(.NUM_RST(3), .DIV_WIDTH(8)) if0 ();
    ck_rst_seq_if #(.NUM_RST(4), .DIV_WIDTH(8)) if1 ();

    assign if0.sw_rst_req = sw;
    assign if0.div_val    = dv;
    assign if1.sw_rst_req = sw;
    assign if1.div_val    = dv;

    ck_rst_seq u0 (.clk(clk), .reset(reset), .bus(if0));
    ck_rst_seq #(.NUM_RST(4), .STAGGER(0)) u1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int nr(input int d);
        return d == 1 ? 4 : 3;
    endfunction

    function automatic int stg(input int d);
        return d == 1 ? 0 : 2;
    endfunction

    // Model: h counts hold-qualifying edges since the last (re)start; everything derives from it.
    int         ne = 0;
    int         h[2] = '{0, 0};
    int         nt[2] = '{0, 0};
    logic [3:0] e_rst[2] = '{4'h0, 4'h0};
    logic       e_done[2] = '{1'b0, 1'b0};
    logic       e_ck[2] = '{1'b0, 1'b0};

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            ne = 0;
            for (int d = 0; d < 2; d++) begin
                h[d] = 0; nt[d] = 0; e_rst[d] = 4'h0; e_done[d] = 1'b0; e_ck[d] = 1'b0;
            end
        end else begin
            ne++;
            for (int d = 0; d < 2; d++) begin
                int hd;
                hd = 4 + (nr(d) - 1) * stg(d);
                if (sw) h[d] = 0;
                else if (ne - 1 >= 2) h[d]++;
                for (int k = 0; k < 4; k++) e_rst[d][k] = (k < nr(d)) && (h[d] >= 4 + k * stg(d));
                e_done[d] = h[d] >= hd;
                e_ck[d] = 1'b0;
                if (h[d] == hd) nt[d] = h[d] + int'(dv) + 1;
                else if (e_done[d] && h[d] == nt[d]) begin
                    e_ck[d] = 1'b1;
                    nt[d] = h[d] + int'(dv) + 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("rst0", 32'(if0.rst_n_out), 32'(e_rst[0][2:0]));
        chk("done0", 32'(if0.rst_done), 32'(e_done[0]));
        chk("ck0", 32'(if0.ck_en), 32'(e_ck[0]));
        chk("rst1", 32'(if1.rst_n_out), 32'(e_rst[1]));
        chk("done1", 32'(if1.rst_done), 32'(e_done[1]));
        chk("ck1", 32'(if1.ck_en), 32'(e_ck[1]));
    end

    task automatic wait_e(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        // Defaults with div_val=3; second instance releases all bits at E6
        wait_e(5);  chk("t1_e5_rst", 32'(if0.rst_n_out), 32'h0);
                    chk("t2_e5_rst", 32'(if1.rst_n_out), 32'h0);
        wait_e(1);  chk("t1_e6_rst", 32'(if0.rst_n_out), 32'h1);
                    chk("t2_e6_rst", 32'(if1.rst_n_out), 32'hF);
                    chk("t2_e6_done", 32'(if1.rst_done), 32'h1);
        wait_e(1);  chk("t1_e7_rst", 32'(if0.rst_n_out), 32'h1);
        wait_e(1);  chk("t1_e8_rst", 32'(if0.rst_n_out), 32'h3);
        wait_e(1);  chk("t1_e9_done", 32'(if0.rst_done), 32'h0);
        wait_e(1);  chk("t1_e10_rst", 32'(if0.rst_n_out), 32'h7);
                    chk("t1_e10_done", 32'(if0.rst_done), 32'h1);
        wait_e(3);  chk("t1_e13_ck", 32'(if0.ck_en), 32'h0);
        wait_e(1);  chk("t1_e14_ck", 32'(if0.ck_en), 32'h1);
        wait_e(4);  chk("t1_e18_ck", 32'(if0.ck_en), 32'h1);
        // One-cycle software request in RUN
        @(negedge clk); sw = 1'b1;
        wait_e(1);  chk("t3_ex_rst", 32'(if0.rst_n_out), 32'h0);
                    chk("t3_ex_done", 32'(if0.rst_done), 32'h0);
                    chk("t3_ex_ck", 32'(if0.ck_en), 32'h0);
        @(negedge clk); sw = 1'b0;
        wait_e(3);  chk("t3_ex3_rst", 32'(if0.rst_n_out), 32'h0);
        wait_e(1);  chk("t3_ex4_rst", 32'(if0.rst_n_out), 32'h1);
        wait_e(4);  chk("t3_ex8_rst", 32'(if0.rst_n_out), 32'h7);
        wait_e(3);  chk("t3_ex11_ck", 32'(if0.ck_en), 32'h0);
        wait_e(1);  chk("t3_ex12_ck", 32'(if0.ck_en), 32'h1);
        // div_val change mid-period, then zero
        @(negedge clk); dv = 8'd1;
        wait_e(3);  chk("t5_ex15_ck", 32'(if0.ck_en), 32'h0);
        wait_e(1);  chk("t5_ex16_ck", 32'(if0.ck_en), 32'h1);
        wait_e(1);  chk("t5_ex17_ck", 32'(if0.ck_en), 32'h0);
        wait_e(1);  chk("t5_ex18_ck", 32'(if0.ck_en), 32'h1);
        @(negedge clk); dv = 8'd0;
        wait_e(1);  chk("t5_ex19_ck", 32'(if0.ck_en), 32'h0);
        for (int i = 0; i < 5; i++) begin
            wait_e(1); chk("t5_zero_ck", 32'(if0.ck_en), 32'h1);
        end
        // Async reset during RELEASE
        @(negedge clk); dv = 8'd3; reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        wait_e(7);  chk("t4_e7_rst", 32'(if0.rst_n_out), 32'h1);
        #2 reset = 1'b0;
        #1          chk("t4_async_rst0", 32'(if0.rst_n_out), 32'h0);
                    chk("t4_async_rst1", 32'(if1.rst_n_out), 32'h0);
                    chk("t4_async_done1", 32'(if1.rst_done), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_e(6);  chk("t4_e6_rst", 32'(if0.rst_n_out), 32'h1);
        wait_e(4);  chk("t4_e10_rst", 32'(if0.rst_n_out), 32'h7);
        // Software request held through HOLD
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        wait_e(3);
        @(negedge clk); sw = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_held_rst", 32'(if0.rst_n_out), 32'h0);
        sw = 1'b0;
        wait_e(3);  chk("t6_d3_rst", 32'(if0.rst_n_out), 32'h0);
        wait_e(1);  chk("t6_d4_rst", 32'(if0.rst_n_out), 32'h1);
                    chk("t6_d4_rst1", 32'(if1.rst_n_out), 32'hF);
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
